// File: rtl/wb_pipe_mem_if.sv
// Wishbone bus bundle shared by the pipelined memory responder and its masters.
// dat_w carries master-to-slave write data, dat_r carries slave-to-master read data.
interface if_wb #(
    parameter int AWIDTH = 27,
    parameter int DWIDTH = 32
);
    logic                  cyc;
    logic                  stb;
    logic                  we;
    logic [AWIDTH-1:0]     adr;
    logic [DWIDTH/8-1:0]   sel;
    logic [DWIDTH-1:0]     dat_w;
    logic [DWIDTH-1:0]     dat_r;
    logic                  ack;
    logic                  stall;

    modport slave (
        input  cyc, stb, we, adr, sel, dat_w,
        output dat_r, ack, stall
    );

    modport master (
        output cyc, stb, we, adr, sel, dat_w,
        input  dat_r, ack, stall
    );
endinterface

// File: rtl/wb_pipe_mem.sv
// Pipelined Wishbone responder backed by an internal word RAM.
// Every accepted beat is acked exactly LATENCY cycles later, in acceptance order.
// Optional periodic stall injection (STALL_EVERY > 0) exercises the master's stall path.
// Optional feature macro: WB_MEM_ERR_EN -- when defined, beats whose address has
// nonzero bits above the RAM index are flagged on err_o instead of ack and do not write.
module wb_pipe_mem #(
    parameter int AWIDTH      = 27,
    parameter int DWIDTH      = 32,
    parameter int MEMBITS     = 12,
    parameter int LATENCY     = 2,
    parameter int STALL_EVERY = 0
) (
    input  logic  clk_i,
    input  logic  rst_i,
    if_wb.slave   bus,
    output logic  err_o
);

    localparam int BYTEBITS = $clog2(DWIDTH/8);
    localparam int LANES    = DWIDTH/8;
    localparam int DEPTH    = 1 << MEMBITS;

    logic [DWIDTH-1:0]  mem_q [DEPTH];
    logic [MEMBITS-1:0] wordIdx;
    logic [DWIDTH-1:0]  memRdData;
    logic               outOfRange;
    logic               unusedAdrBits;
    logic               stallInt;
    logic               accept;

    logic [LATENCY-1:0] pipeValid_q, pipeValid_d;
    logic [LATENCY-1:0] pipeErr_q,   pipeErr_d;
    logic [DWIDTH-1:0]  pipeData_q [LATENCY];
    logic [DWIDTH-1:0]  pipeData_d [LATENCY];

    // Upper address bits are ignored for indexing, so the RAM aliases across the bus space.
    assign wordIdx   = bus.adr[BYTEBITS+MEMBITS-1:BYTEBITS];
    assign memRdData = mem_q[wordIdx];

`ifdef WB_MEM_ERR_EN
    assign outOfRange    = |bus.adr[AWIDTH-1:BYTEBITS+MEMBITS];
    assign unusedAdrBits = ^bus.adr[BYTEBITS-1:0];
`else
    assign outOfRange    = 1'b0;
    assign unusedAdrBits = ^{bus.adr[AWIDTH-1:BYTEBITS+MEMBITS], bus.adr[BYTEBITS-1:0]};
`endif

    // A beat is taken only when the master holds cyc and stb and we are not stalling.
    assign accept = bus.cyc & bus.stb & ~stallInt;

    // RAM write port: commit enabled byte lanes in the acceptance cycle; contents are never reset.
    always_ff @(posedge clk_i) begin
        if (accept && bus.we && !outOfRange) begin
            for (int b = 0; b < LANES; b++) begin
                if (bus.sel[b]) begin
                    mem_q[wordIdx][b*8 +: 8] <= bus.dat_w[b*8 +: 8];
                end
            end
        end
    end

    // Ack pipeline next state: shift one stage per cycle; dropping cyc empties every stage.
    always_comb begin
        pipeValid_d = '0;
        pipeErr_d   = '0;
        for (int i = 0; i < LATENCY; i++) begin
            pipeData_d[i] = '0;
        end
        if (bus.cyc) begin
            pipeValid_d[0] = accept;
            pipeErr_d[0]   = accept & outOfRange;
            pipeData_d[0]  = (accept && !bus.we && !outOfRange) ? memRdData : '0;
            for (int i = 1; i < LATENCY; i++) begin
                pipeValid_d[i] = pipeValid_q[i-1];
                pipeErr_d[i]   = pipeErr_q[i-1];
                pipeData_d[i]  = pipeData_q[i-1];
            end
        end
    end

    // Ack pipeline registers; reset empties the pipeline immediately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pipeValid_q <= '0;
            pipeErr_q   <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pipeData_q[i] <= '0;
            end
        end else begin
            pipeValid_q <= pipeValid_d;
            pipeErr_q   <= pipeErr_d;
            pipeData_q  <= pipeData_d;
        end
    end

    generate
        if (STALL_EVERY > 0) begin : gStall
            localparam int CW = $clog2(STALL_EVERY + 1);
            logic [CW-1:0] beatCnt_q, beatCnt_d;

            // Beat counter: counts accepted beats, clears on the stall cycle or when cyc drops.
            always_comb begin
                beatCnt_d = beatCnt_q;
                if (!bus.cyc || stallInt) begin
                    beatCnt_d = '0;
                end else if (accept) begin
                    beatCnt_d = beatCnt_q + CW'(1);
                end
            end

            // Beat counter register.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    beatCnt_q <= '0;
                end else begin
                    beatCnt_q <= beatCnt_d;
                end
            end

            // Stall depends on registered state only, never on the incoming strobe.
            assign stallInt = (beatCnt_q == CW'(STALL_EVERY));
        end else begin : gNoStall
            assign stallInt = 1'b0;
        end
    endgenerate

    assign bus.stall = stallInt;
    assign bus.ack   = pipeValid_q[LATENCY-1] & ~pipeErr_q[LATENCY-1];
    assign bus.dat_r = pipeData_q[LATENCY-1];

`ifdef WB_MEM_ERR_EN
    assign err_o = pipeValid_q[LATENCY-1] & pipeErr_q[LATENCY-1];
`else
    assign err_o = 1'b0;
`endif

endmodule
